// File: rtl/jtag_dap_pkg.sv
// jtag_dap_pkg: TAP state codes, DAP opcodes, AHB constants and the TAP next-state function
package jtag_dap_pkg;
  localparam logic [3:0] TAP_EX2_DR   = 4'h0;
  localparam logic [3:0] TAP_EX1_DR   = 4'h1;
  localparam logic [3:0] TAP_SHIFT_DR = 4'h2;
  localparam logic [3:0] TAP_PAUSE_DR = 4'h3;
  localparam logic [3:0] TAP_SEL_IR   = 4'h4;
  localparam logic [3:0] TAP_UPD_DR   = 4'h5;
  localparam logic [3:0] TAP_CAP_DR   = 4'h6;
  localparam logic [3:0] TAP_SEL_DR   = 4'h7;
  localparam logic [3:0] TAP_EX2_IR   = 4'h8;
  localparam logic [3:0] TAP_EX1_IR   = 4'h9;
  localparam logic [3:0] TAP_SHIFT_IR = 4'hA;
  localparam logic [3:0] TAP_PAUSE_IR = 4'hB;
  localparam logic [3:0] TAP_RTI      = 4'hC;
  localparam logic [3:0] TAP_UPD_IR   = 4'hD;
  localparam logic [3:0] TAP_CAP_IR   = 4'hE;
  localparam logic [3:0] TAP_TLR      = 4'hF;
  localparam int OP_IDCODE = 1;
  localparam int OP_ADDR   = 2;
  localparam int OP_WDATA  = 3;
  localparam int OP_RDATA  = 4;
  localparam int OP_STATUS = 5;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_IDLE = 2'd0;
  localparam logic [1:0] AHB_ADDR = 2'd1;
  localparam logic [1:0] AHB_DATA = 2'd2;
  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    case (s)
      TAP_TLR:      return tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:      return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:   return tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR:   return tms ? TAP_EX1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: return tms ? TAP_EX1_DR : TAP_SHIFT_DR;
      TAP_EX1_DR:   return tms ? TAP_UPD_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR: return tms ? TAP_EX2_DR : TAP_PAUSE_DR;
      TAP_EX2_DR:   return tms ? TAP_UPD_DR : TAP_SHIFT_DR;
      TAP_UPD_DR:   return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR:   return tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR:   return tms ? TAP_EX1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: return tms ? TAP_EX1_IR : TAP_SHIFT_IR;
      TAP_EX1_IR:   return tms ? TAP_UPD_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR: return tms ? TAP_EX2_IR : TAP_PAUSE_IR;
      TAP_EX2_IR:   return tms ? TAP_UPD_IR : TAP_SHIFT_IR;
      TAP_UPD_IR:   return tms ? TAP_SEL_DR : TAP_RTI;
    endcase
  endfunction
endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: IEEE 1149.1 TAP state machine with decoded one-hot strobes
module jtag_tap_fsm
  import jtag_dap_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_i,
  input  logic       tms_i,
  output logic [3:0] state_o,
  output logic       tlr_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o
);
  logic [3:0] state_q;
  always_ff @(posedge tck_i or posedge trst_i)
    if (trst_i) state_q <= TAP_TLR;
    else state_q <= tap_next(state_q, tms_i);
  assign state_o      = state_q;
  assign tlr_o        = state_q == TAP_TLR;
  assign capture_dr_o = state_q == TAP_CAP_DR;
  assign shift_dr_o   = state_q == TAP_SHIFT_DR;
  assign update_dr_o  = state_q == TAP_UPD_DR;
  assign capture_ir_o = state_q == TAP_CAP_IR;
  assign shift_ir_o   = state_q == TAP_SHIFT_IR;
  assign update_ir_o  = state_q == TAP_UPD_IR;
endmodule

// File: rtl/jtag_ahb_dap.sv
// jtag_ahb_dap: JTAG debug access port driving single AHB-Lite transfers, all on TCK
module jtag_ahb_dap
  import jtag_dap_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] IDCODE_VAL = 32'hF0F0F0F1,
  parameter int          AUTO_INC   = 1
) (
  input  logic                  TCK,
  input  logic                  TRST,
  input  logic                  TMS,
  input  logic                  TDI,
  output logic                  TDO,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic                  HWRITE,
  output logic [1:0]            HTRANS,
  output logic [DATA_WIDTH-1:0] HWDATA
);
  localparam int AD  = ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH;
  localparam int DRW = AD > 32 ? AD : 32;
  localparam int MW  = $clog2(DRW);
  logic [3:0] tap_state;
  logic tlr, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;
  logic [IR_WIDTH-1:0] ir_q, ir_sr_q, ir_sr_d;
  logic [DRW-1:0] dr_q, dr_d, cap_val;
  logic [MW-1:0] dr_msb;
  logic [1:0] ahb_q, ahb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic dir_q, dir_d, rvalid_q, rvalid_d, err_q, err_d, ovr_q, ovr_d, tdo_q;
  logic is_id, is_addr, is_wd, is_rd, is_st, busy, launch, done, ok_done, st_upd;
  jtag_tap_fsm u_tap (
    .tck_i        (TCK),
    .trst_i       (TRST),
    .tms_i        (TMS),
    .state_o      (tap_state),
    .tlr_o        (tlr),
    .capture_dr_o (capture_dr),
    .shift_dr_o   (shift_dr),
    .update_dr_o  (update_dr),
    .capture_ir_o (capture_ir),
    .shift_ir_o   (shift_ir),
    .update_ir_o  (update_ir)
  );
  assign is_id   = ir_q == IR_WIDTH'(OP_IDCODE);
  assign is_addr = ir_q == IR_WIDTH'(OP_ADDR);
  assign is_wd   = ir_q == IR_WIDTH'(OP_WDATA);
  assign is_rd   = ir_q == IR_WIDTH'(OP_RDATA);
  assign is_st   = ir_q == IR_WIDTH'(OP_STATUS);
  assign busy    = ahb_q != AHB_IDLE;
  assign launch  = update_dr & (is_wd | is_rd);
  assign done    = ahb_q == AHB_DATA & HREADY;
  assign ok_done = done & ~HRESP;
  assign st_upd  = update_dr & is_st;
  assign cap_val = is_id ? DRW'(IDCODE_VAL) : is_addr ? DRW'(addr_q) : is_rd ? DRW'(rdata_q) :
                   is_st ? DRW'({ovr_q, err_q, busy, rvalid_q}) : '0;
  assign dr_msb  = (is_id | is_st) ? MW'(31) : is_addr ? MW'(ADDR_WIDTH-1) :
                   (is_wd | is_rd) ? MW'(DATA_WIDTH-1) : '0;
  assign ir_sr_d = capture_ir ? IR_WIDTH'(1) : shift_ir ? {TDI, ir_sr_q[IR_WIDTH-1:1]} : ir_sr_q;
  // one shared shifter; TDI enters at the top of whichever DR is selected
  always_comb begin
    dr_d = dr_q;
    if (capture_dr) dr_d = cap_val;
    else if (shift_dr) begin
      dr_d = dr_q >> 1;
      dr_d[dr_msb] = TDI;
    end
  end
  always_comb begin
    ahb_d    = ahb_q == AHB_IDLE ? (launch ? AHB_ADDR : AHB_IDLE) :
               ahb_q == AHB_ADDR ? (HREADY ? AHB_DATA : AHB_ADDR) : (HREADY ? AHB_IDLE : ahb_q);
    addr_d   = update_dr & is_addr ? dr_q[ADDR_WIDTH-1:0] :
               ok_done & (AUTO_INC != 0) ? addr_q + ADDR_WIDTH'(DATA_WIDTH/8) : addr_q;
    wdata_d  = update_dr & is_wd ? dr_q[DATA_WIDTH-1:0] : wdata_q;
    dir_d    = launch & ~busy ? is_wd : dir_q;
    rdata_d  = ok_done & ~dir_q ? HRDATA : rdata_q;
    rvalid_d = launch & ~busy & is_rd ? 1'b0 : ok_done & ~dir_q ? 1'b1 : rvalid_q;
    err_d    = (done & HRESP) | (err_q & ~(st_upd & dr_q[2]));
    ovr_d    = (launch & busy) | (ovr_q & ~(st_upd & dr_q[3]));
  end
  always_ff @(posedge TCK or posedge TRST)
    if (TRST) begin
      ir_sr_q  <= '0;
      dr_q     <= '0;
      ahb_q    <= AHB_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      dir_q    <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      dr_q     <= dr_d;
      ahb_q    <= ahb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      dir_q    <= dir_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
    end
  always_ff @(negedge TCK or posedge TRST)
    if (TRST) begin
      ir_q  <= IR_WIDTH'(OP_IDCODE);
      tdo_q <= 1'b0;
    end else begin
      ir_q  <= tlr ? IR_WIDTH'(OP_IDCODE) : update_ir ? ir_sr_q : ir_q;
      tdo_q <= tap_state == TAP_SHIFT_IR ? ir_sr_q[0] : tap_state == TAP_SHIFT_DR & dr_q[0];
    end
  assign TDO    = tdo_q;
  assign HTRANS = ahb_q == AHB_ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = addr_q;
  assign HWRITE = dir_q;
  assign HWDATA = ahb_q == AHB_DATA & dir_q ? wdata_q : '0;
endmodule

// File: tb/tb_jtag_ahb_dap.sv
// tb_jtag_ahb_dap: JTAG-driven scoreboard bench for the AHB debug access port
module tb_jtag_ahb_dap;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } xfer_t;
  logic TCK = 0, TRST = 1, TMS = 1, TDI = 0, TDO;
  logic HREADY = 1, HRESP = 0, HWRITE;
  logic [31:0] HRDATA = '0, HADDR, HWDATA;
  logic [1:0] HTRANS;
  int total = 0, bad = 0, xfers = 0;
  xfer_t sb[$];
  xfer_t cur;
  bit dph = 0;
  jtag_ahb_dap dut (
    .TCK    (TCK),
    .TRST   (TRST),
    .TMS    (TMS),
    .TDI    (TDI),
    .TDO    (TDO),
    .HREADY (HREADY),
    .HRESP  (HRESP),
    .HRDATA (HRDATA),
    .HADDR  (HADDR),
    .HWRITE (HWRITE),
    .HTRANS (HTRANS),
    .HWDATA (HWDATA)
  );
  always #5 TCK = ~TCK;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic tms, input logic tdi, output logic tdo);
    @(negedge TCK);
    #1;
    tdo = TDO;
    TMS = tms;
    TDI = tdi;
  endtask
  task automatic idle(input int n);
    logic b;
    repeat (n) step(0, 0, b);
  endtask
  task automatic scan_ir(input logic [3:0] v, output logic [3:0] o);
    logic b;
    o = '0;
    step(1, 0, b); step(1, 0, b); step(0, 0, b); step(0, 0, b);
    for (int i = 0; i < 4; i++) begin step(i == 3, v[i], b); o[i] = b; end
    step(1, 0, b); step(0, 0, b);
  endtask
  task automatic scan_dr(input int n, input logic [31:0] v, output logic [31:0] o);
    logic b;
    o = '0;
    step(1, 0, b); step(0, 0, b); step(0, 0, b);
    for (int i = 0; i < n; i++) begin step(i == n - 1, v[i], b); o[i] = b; end
    step(1, 0, b); step(0, 0, b);
  endtask
  task automatic push(input logic [31:0] a, input logic w, input logic [31:0] d);
    sb.push_back(xfer_t'{addr: a, write: w, wdata: d});
  endtask
  // bus monitor samples just before each rising edge
  always @(negedge TCK) begin
    #4;
    if (TRST) dph = 0;
    else begin
      if (dph && HREADY) begin
        dph = 0;
        if (cur.write) check("hwdata", HWDATA, cur.wdata);
      end
      if (HTRANS == 2'b10 && HREADY) begin
        xfers++;
        if (sb.size() == 0) check("unexpected_xfer", HADDR, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          cur = sb.pop_front();
          check("haddr", HADDR, cur.addr);
          check("hwrite", HWRITE, cur.write);
          dph = 1;
        end
      end
    end
  end
  initial begin
    logic [31:0] o;
    logic [3:0] io;
    logic b;
    repeat (2) @(negedge TCK);
    #1;
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_haddr", HADDR, 0);
    check("rst_hwrite", HWRITE, 0);
    check("rst_hwdata", HWDATA, 0);
    check("rst_tdo", TDO, 0);
    TRST = 0;
    step(0, 0, b);
    scan_dr(32, 0, o);
    check("idcode", o, 32'hF0F0F0F1);
    scan_ir(4'hF, io);
    check("ir_capture", io, 4'b0001);
    scan_dr(8, 8'hA5, o);
    check("bypass", o, 8'h4A);
    scan_ir(4'h7, io);
    scan_dr(8, 8'h3C, o);
    check("bypass_undef", o, 8'h78);
    scan_ir(4'd2, io);
    repeat (5) step(1, 0, b);
    step(0, 0, b);
    scan_dr(32, 0, o);
    check("tlr_idcode", o, 32'hF0F0F0F1);
    // write with zero wait states
    scan_ir(4'd2, io);
    scan_dr(32, 32'h0000_1000, o);
    check("addr_rst", o, 0);
    scan_ir(4'd3, io);
    push(32'h1000, 1, 32'hDEADBEEF);
    scan_dr(32, 32'hDEADBEEF, o);
    check("wdata_cap", o, 0);
    idle(4);
    scan_ir(4'd2, io);
    scan_dr(32, 32'h0000_3000, o);
    check("addr_inc", o, 32'h1004);
    // error response
    scan_ir(4'd3, io);
    HRESP = 1;
    push(32'h3000, 1, 32'h55AA55AA);
    scan_dr(32, 32'h55AA55AA, o);
    idle(4);
    HRESP = 0;
    scan_ir(4'd5, io);
    scan_dr(32, 32'h4, o);
    check("status_err", o, 32'h4);
    scan_dr(32, 0, o);
    check("status_clr", o, 0);
    scan_ir(4'd2, io);
    scan_dr(32, 32'h0000_2000, o);
    check("addr_err_hold", o, 32'h3000);
    // read with wait states
    HREADY = 0;
    HRDATA = 32'h12345678;
    scan_ir(4'd4, io);
    push(32'h2000, 0, 0);
    scan_dr(32, 0, o);
    check("rdata_rst", o, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, b);
      check("htrans_hold", HTRANS, 2'b10);
    end
    check("haddr_hold", HADDR, 32'h2000);
    HREADY = 1;
    idle(3);
    scan_ir(4'd5, io);
    scan_dr(32, 0, o);
    check("status_rvalid", o, 32'h1);
    scan_ir(4'd4, io);
    HRDATA = 32'hCAFEF00D;
    push(32'h2004, 0, 0);
    scan_dr(32, 0, o);
    check("rdata1", o, 32'h12345678);
    idle(4);
    HRDATA = 32'h0BAD_0BAD;
    push(32'h2008, 0, 0);
    scan_dr(32, 0, o);
    check("rdata2", o, 32'hCAFEF00D);
    idle(4);
    // overrun: second launch while stalled is dropped but still loads WDATA
    HREADY = 0;
    scan_ir(4'd3, io);
    push(32'h200C, 1, 32'h33334444);
    scan_dr(32, 32'h11112222, o);
    scan_dr(32, 32'h33334444, o);
    HREADY = 1;
    idle(4);
    scan_ir(4'd5, io);
    scan_dr(32, 32'h8, o);
    check("status_ovr", o, 32'h9);
    scan_dr(32, 0, o);
    check("status_ovr_clr", o, 32'h1);
    check("xfer_count", xfers, 6);
    // async reset in the middle of an address phase
    HREADY = 0;
    scan_ir(4'd3, io);
    scan_dr(32, 32'hABCD0123, o);
    step(0, 0, b);
    check("t6_nonseq", HTRANS, 2'b10);
    #2 TRST = 1;
    #1;
    check("t6_htrans_rst", HTRANS, 2'b00);
    check("t6_haddr_rst", HADDR, 0);
    HREADY = 1;
    @(negedge TCK);
    #1 TRST = 0;
    step(0, 0, b);
    scan_dr(32, 0, o);
    check("t6_idcode", o, 32'hF0F0F0F1);
    scan_ir(4'hF, io);
    check("t6_ir_capture", io, 4'b0001);
    idle(4);
    check("sb_empty", sb.size(), 0);
    check("xfer_final", xfers, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
